// File: rtl/bram_sp_arb.sv
// Two-port arbiter in front of a single-port BRAM. Ports A and B each present
// a request that is granted combinationally. The winning access is registered
// onto the BRAM interface, and read returns are tracked so that each read
// raises the rvalid of the port that issued it.
module bram_sp_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  port_t                 rr_ptr;
  logic                  xfer;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic                  rd_vld;
  port_t                 rd_port;

  // Grant decision. It depends only on the live requests and the round-robin
  // pointer, and it is forced low while reset is held.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && !b_req) begin
        a_gnt = 1'b1;
      end else if (b_req && !a_req) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        if ((FIXED_PRIO != 0) || (rr_ptr == PORT_A)) begin
          a_gnt = 1'b1;
        end else begin
          b_gnt = 1'b1;
        end
      end
    end
  end

  // Select the winning port's request fields for the BRAM registers.
  always_comb begin
    xfer     = a_gnt | b_gnt;
    sel_wr   = b_gnt ? b_wr   : a_wr;
    sel_addr = b_gnt ? b_addr : a_addr;
    sel_din  = b_gnt ? b_din  : a_din;
  end

  // After each transfer the round-robin pointer moves to the port that did not transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PORT_A;
    end else if (xfer) begin
      rr_ptr <= a_gnt ? PORT_B : PORT_A;
    end
  end

  // BRAM interface registers. The address and data hold while idle, and the write strobe is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_wr   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else if (xfer) begin
      bram_wr   <= sel_wr;
      bram_addr <= sel_addr;
      bram_din  <= sel_din;
    end else begin
      bram_wr   <= 1'b0;
    end
  end

  // Read-return pipeline. Stage 1 marks a read issued to the BRAM, and stage 2 is the per-port rvalid pulse aligned with bram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      rd_port  <= PORT_A;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      rd_vld   <= xfer & ~sel_wr;
      rd_port  <= b_gnt ? PORT_B : PORT_A;
      a_rvalid <= rd_vld & (rd_port == PORT_A);
      b_rvalid <= rd_vld & (rd_port == PORT_B);
    end
  end

  assign rdata = bram_dout;

endmodule

// File: tb/tb_bram_sp_arb.sv
// Self-checking bench for bram_sp_arb. The bench builds its own reference
// model of the arbitration and the memory contents. Each read is pushed onto
// a scoreboard together with its expected data and its due cycle. A second
// instance with FIXED_PRIO=1 is driven with the same inputs, and only its
// grants are checked.
module tb_bram_sp_arb;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, bram_wr;
  logic [DW-1:0] rdata, bram_din, bram_dout;
  logic [AW-1:0] bram_addr;

  logic          f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_bram_wr;
  logic [DW-1:0] f_rdata, f_bram_din, f_bram_dout;
  logic [AW-1:0] f_bram_addr;

  logic [DW-1:0] mem0 [2**AW];
  logic [DW-1:0] mem1 [2**AW];
  logic [DW-1:0] model_mem [2**AW];

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic model_rr = 1'b0;
  logic pend_wr = 1'b0;
  logic win = 1'b0;
  int   win_a = 0, win_b = 0, win_fa = 0, win_fb = 0;

  bram_sp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .bram_wr(bram_wr), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  bram_sp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid),
    .rdata(f_rdata), .bram_wr(f_bram_wr), .bram_addr(f_bram_addr),
    .bram_din(f_bram_din), .bram_dout(f_bram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous BRAM models, read-first.
  always @(posedge clk) begin
    if (bram_wr) mem0[bram_addr] <= bram_din;
    bram_dout <= mem0[bram_addr];
    if (f_bram_wr) mem1[f_bram_addr] <= f_bram_din;
    f_bram_dout <= mem1[f_bram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_wr = aw; a_addr = aa; a_din = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_din = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Monitor: check outputs against the reference model, then advance the model for the upcoming edge.
  always @(negedge clk) begin
    logic exp_a, exp_b, due_now;
    logic wr_x;
    logic [AW-1:0] addr_x;
    logic [DW-1:0] din_x;
    exp_t e;
    if (!rst_n) begin
      checkOutput("rst_a_gnt", a_gnt, 0);
      checkOutput("rst_b_gnt", b_gnt, 0);
      checkOutput("rst_a_rvalid", a_rvalid, 0);
      checkOutput("rst_b_rvalid", b_rvalid, 0);
      checkOutput("rst_bram_wr", bram_wr, 0);
      checkOutput("rst_bram_addr", bram_addr, 0);
      checkOutput("rst_bram_din", bram_din, 0);
      checkOutput("rst_fixed_gnt", {f_a_gnt, f_b_gnt}, 0);
      sb.delete();
      model_rr = 1'b0;
      pend_wr = 1'b0;
    end else begin
      due_now = (sb.size() > 0) && (sb[0].due == cyc);
      checkOutput("a_rvalid", a_rvalid, due_now && (sb[0].port == 1'b0));
      checkOutput("b_rvalid", b_rvalid, due_now && (sb[0].port == 1'b1));
      if (due_now) begin
        checkOutput("rdata", rdata, sb[0].data);
        void'(sb.pop_front());
      end
      if ((sb.size() > 0) && (sb[0].due < cyc)) begin
        checkOutput("sb_overdue", 1, 0);
        void'(sb.pop_front());
      end
      checkOutput("bram_wr", bram_wr, pend_wr);

      exp_a = a_req && (!b_req || !model_rr);
      exp_b = b_req && (!a_req || model_rr);
      checkOutput("a_gnt", a_gnt, exp_a);
      checkOutput("b_gnt", b_gnt, exp_b);
      checkOutput("fixed_a_gnt", f_a_gnt, a_req);
      checkOutput("fixed_b_gnt", f_b_gnt, b_req && !a_req);
      if (win) begin
        win_a += int'(a_gnt);
        win_b += int'(b_gnt);
        win_fa += int'(f_a_gnt);
        win_fb += int'(f_b_gnt);
      end

      pend_wr = 1'b0;
      if (exp_a || exp_b) begin
        wr_x   = exp_b ? b_wr : a_wr;
        addr_x = exp_b ? b_addr : a_addr;
        din_x  = exp_b ? b_din : a_din;
        pend_wr = wr_x;
        if (wr_x) begin
          model_mem[addr_x] = din_x;
        end else begin
          e.port = exp_b;
          e.data = model_mem[addr_x];
          e.due  = cyc + 2;
          sb.push_back(e);
        end
        model_rr = exp_a;
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
    rst_n = 1'b0;
    // Requests held during reset must not be granted.
    a_req = 1; a_wr = 0; a_addr = '0; a_din = '0;
    b_req = 1; b_wr = 0; b_addr = '0; b_din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Port A writes DEADBEEF to address 3, then port B reads it back.
    applyStimulus(1, 1, 4'd3, 32'hDEADBEEF, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 4'd3, '0);
    idle(3);

    // A write to address 5 is followed immediately by a read of the same address.
    applyStimulus(1, 1, 4'd5, 32'h1, 0, 0, '0, '0);
    applyStimulus(1, 0, 4'd5, '0, 0, 0, '0, '0);
    idle(3);

    // Alternating-port reads issued back to back.
    applyStimulus(0, 0, '0, '0, 1, 1, 4'd1, 32'h11111111);
    applyStimulus(1, 1, 4'd2, 32'h22222222, 0, 0, '0, '0);
    applyStimulus(1, 0, 4'd1, '0, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 4'd2, '0);
    applyStimulus(1, 0, 4'd1, '0, 0, 0, '0, '0);
    idle(3);

    // Restart from reset so the round-robin pointer starts at A, then hold both requests for 8 cycles.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    win = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 4'd1, '0, 1, 0, 4'd2, '0);
    win = 1'b0;
    idle(3);

    // Reset arrives while a read is in flight, so its return must be discarded.
    applyStimulus(1, 0, 4'd3, '0, 0, 0, '0, '0);
    rst_n = 1'b0;
    a_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    checkOutput("sb_drained", sb.size(), 0);
    checkOutput("rr_a_count", win_a, 4);
    checkOutput("rr_b_count", win_b, 4);
    checkOutput("fixed_a_count", win_fa, 8);
    checkOutput("fixed_b_count", win_fb, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
